// File: rtl/mux_canales_pkg.sv
// rtl/mux_canales_pkg.sv - shared constants and width helper for mux_canales_reg
package mux_canales_pkg;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam logic [31:0] OUT_DATA_RST = 32'd0;
  localparam int          RR_PTR_RST   = 0;

endpackage

// File: rtl/mux_canales_reg_arbitro_rr.sv
// rtl/mux_canales_reg_arbitro_rr.sv - combinational rotating-priority arbiter
// Grants the first requester found from ptr upward, wrapping N_CH-1 -> 0.
module arbitro_rr
  import mux_canales_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2_int(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % N_CH);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_canales_reg.sv
// rtl/mux_canales_reg.sv - N-channel registered selector with valid/ready per channel
// MUX_CANALES_RR_EN builds the round-robin arbiter; otherwise mode_rr is ignored.
module mux_canales_reg
  import mux_canales_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = clog2_int(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode_rr,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_ch
);

  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             fixed_vld;
  logic             can_load;
  logic             xfer_in;
  logic [W-1:0]     sel_word;

  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  assign fixed_vld = (int'(sel) < N_CH);

`ifdef MUX_CANALES_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_vld;

  arbitro_rr #(.N_CH(N_CH)) u_arbitro_rr (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    grant_idx = sel;
    grant_vld = fixed_vld;
    if (mode_rr == MODE_RR) begin
      grant_idx = arb_idx;
      grant_vld = arb_vld;
    end
  end

  // Pointer only advances on round-robin accepts, so a fixed-mode detour keeps it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer_in && mode_rr == MODE_RR)
      rr_ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= SEL_W'(RR_PTR_RST);
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  logic unused_mode_rr;
  assign unused_mode_rr = mode_rr;
  assign grant_idx      = sel;
  assign grant_vld      = fixed_vld;
`endif

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++)
      in_ready[i] = !reset && can_load && grant_vld && (grant_idx == SEL_W'(i));
  end

  assign xfer_in = |(in_valid & in_ready);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant_idx == SEL_W'(i)) sel_word = in_data[i*W +: W];
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer_in) begin
      out_data_d  = sel_word;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= OUT_DATA_RST[W-1:0];
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_canales_reg.sv
// tb/tb_mux_canales_reg.sv - scoreboard bench for mux_canales_reg (4-ch and 3-ch instances)
module tb_mux_canales_reg;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        mode_rr;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_ch;

  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3, out_ready3;
  logic [1:0]  out_ch3;

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;
  int mq[$];
  int m_ptr = 0;

  always #5 clk = ~clk;

  mux_canales_reg #(.N_CH(4), .W(8)) dut (
    .clk(clk), .reset(reset), .sel(sel), .mode_rr(mode_rr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  mux_canales_reg #(.N_CH(3), .W(8)) dut3 (
    .clk(clk), .reset(reset), .sel(sel3), .mode_rr(1'b0),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pending output words live in mq; expected grant follows the selection rules.
  always @(negedge clk) begin : cmp
    int         g;
    logic       m_vld;
    logic [3:0] exp_rdy;
    logic       rr;
    if (!check_en) begin
      mq.delete();
      m_ptr = 0;
    end else begin
`ifdef MUX_CANALES_RR_EN
      rr = mode_rr;
`else
      rr = 1'b0;
`endif
      g = -1;
      if (rr) begin
        for (int k = N - 1; k >= 0; k--)
          if (in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end else if (int'(sel) < N) begin
        g = int'(sel);
      end
      m_vld   = (mq.size() != 0);
      exp_rdy = ((!m_vld || out_ready) && g >= 0) ? 4'(1 << g) : 4'd0;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_vld));
      if (m_vld) begin
        check("out_data", 32'(out_data), mq[0] & 32'hff);
        check("out_ch", 32'(out_ch), 32'(mq[0] >> 8));
      end
      check("dut3_in_ready", 32'(in_ready3), 32'd0);
      check("dut3_out_valid", 32'(out_valid3), 32'd0);
      if (m_vld && out_ready) void'(mq.pop_front());
      if (exp_rdy != 4'd0 && in_valid[g]) begin
        mq.push_back(int'(in_data[g*8 +: 8]) | (g << 8));
        if (rr) m_ptr = (g + 1) % N;
      end
    end
  end

`ifdef MUX_CANALES_RR_EN
  int seq_a[5] = '{0, 1, 2, 3, 0};
  int seq_b[4] = '{1, 3, 1, 3};
`endif

  initial begin
    reset = 1'b1; sel = 2'd2; mode_rr = 1'b0;
    in_data = 32'h0; in_valid = 4'b0100; out_ready = 1'b1;
    sel3 = 2'd3; in_data3 = 24'h123456; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; check_en = 1'b1;
    in_data = 32'h00A5_0000;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'h4);
    step();
    check("fix_out_data", 32'(out_data), 32'hA5);
    check("fix_out_ch", 32'(out_ch), 32'd2);
    check("fix_out_valid", 32'(out_valid), 32'd1);

    out_ready = 1'b0; in_data = 32'h005A_0000;
    repeat (3) begin
      step();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_data", 32'(out_data), 32'hA5);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h4);
    step();
    check("bp_next_data", 32'(out_data), 32'h5A);
    check("bp_no_bubble", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold_data", 32'(out_data), 32'h5A);
    check("drain_hold_ch", 32'(out_ch), 32'd2);
    check("oor_in_ready", 32'(in_ready3), 32'd0);
    check("oor_out_valid", 32'(out_valid3), 32'd0);

    sel = 2'd1; in_data = 32'h0000_C300; in_valid = 4'b0010; out_ready = 1'b0;
    step();
    check("mid_loaded", 32'(out_valid), 32'd1);
    check_en = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_ch", 32'(out_ch), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0; check_en = 1'b1;

`ifdef MUX_CANALES_RR_EN
    mode_rr = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = $urandom;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_all_ch", 32'(out_ch), 32'(seq_a[i]));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_odd_ch", 32'(out_ch), 32'(seq_b[i]));
    end
`else
    mode_rr = 1'b1; sel = 2'd1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 4'($urandom) | 4'b0010;
      in_data = $urandom;
      #1;
      check("norr_in_ready", 32'(in_ready), 32'h2);
      step();
      check("norr_out_valid", 32'(out_valid), 32'd1);
      check("norr_out_ch", 32'(out_ch), 32'd1);
    end
`endif

    for (int i = 0; i < 400; i++) begin
      sel       = 2'($urandom_range(0, 3));
      mode_rr   = 1'($urandom);
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data3  = 24'($urandom);
      step();
    end

    check_en = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
